// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped I/O port controller.
package io_pkg;

  localparam logic [1:0] IO_ADDR_STATUS = 2'b00;
  localparam logic [1:0] IO_ADDR_DATA   = 2'b01;

  localparam int ST_LED_READY = 0;
  localparam int ST_SW_READY  = 1;

  // Button lanes: btnL signals "LED ready", btnR signals "switches ready".
  localparam int NUM_BTN = 2;
  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;

  localparam int SW_W  = 16;
  localparam int LED_W = 12;

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [1:0]       addr;
    logic [LED_W-1:0] wdata;
  } io_req_t;

  function automatic logic data_hit(input logic strobe, input logic [1:0] addr);
    return strobe && (addr == IO_ADDR_DATA);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button lane: 2-flop synchronizer, hold-time debounce counter and
// rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             stable_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync     <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync     <= {sync[0], btn_raw};
      stable_q <= stable;
      // Any return to the accepted level restarts the hold window.
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_q;

endmodule

// File: rtl/io_port_ctrl.sv
// IO port register file: status/data readback, LED register, debounced
// button flags and button-triggered switch capture.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pRead,
  input  logic             pWrite,
  input  logic [1:0]       addr,
  input  logic [LED_W-1:0] writeData,
  output logic [31:0]      readData,
  input  logic             btnL,
  input  logic             btnR,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led
);

  io_req_t req;
  assign req = '{rd: pRead, wr: pWrite, addr: addr, wdata: writeData};

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_press;
  // Debounced levels are only consumed through the press pulses.
  logic [NUM_BTN-1:0] btn_stable_unused;

  assign btn_raw[BTN_L] = btnL;
  assign btn_raw[BTN_R] = btnR;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw[b]),
      .stable  (btn_stable_unused[b]),
      .press   (btn_press[b])
    );
  end

  logic [1:0][SW_W-1:0] sw_sync;
  logic [SW_W-1:0]      sw_latch;
  logic                 sw_ready;
  logic                 led_ready;
  logic                 rd_data;
  logic                 wr_data;

  assign rd_data = data_hit(req.rd, req.addr);
  assign wr_data = data_hit(req.wr, req.addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_sync   <= '0;
      sw_latch  <= '0;
      sw_ready  <= 1'b0;
      led_ready <= 1'b0;
      led       <= '0;
    end else begin
      sw_sync <= {sw_sync[0], switch};
      if (wr_data) led <= req.wdata;
      // Set beats clear so a press coinciding with the consuming access is kept.
      if (btn_press[BTN_R]) begin
        sw_ready <= 1'b1;
        sw_latch <= sw_sync[1];
      end else if (rd_data) begin
        sw_ready <= 1'b0;
      end
      if (btn_press[BTN_L])  led_ready <= 1'b1;
      else if (wr_data)      led_ready <= 1'b0;
    end
  end

  always_comb begin
    readData = '0;
    case (req.addr)
      IO_ADDR_STATUS: begin
        readData[ST_LED_READY] = led_ready;
        readData[ST_SW_READY]  = sw_ready;
      end
      IO_ADDR_DATA: readData[SW_W-1:0] = sw_latch;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: directed scenarios plus a long randomized run
// checked against a window-based behavioural model.
module tb_io_port_ctrl;
  import io_pkg::*;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pRead = 1'b0, pWrite = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [11:0] writeData = '0;
  logic [15:0] switch = '0;
  logic [31:0] readData;
  logic [11:0] led;

  int checks = 0;
  int errors = 0;

  io_port_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .pRead     (pRead),
    .pWrite    (pWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData),
    .btnL      (btnL),
    .btnR      (btnR),
    .switch    (switch),
    .led       (led)
  );

  always #5 clk = ~clk;

  // Model: a button level is accepted once the D most recent synchronized
  // samples (raw levels from 2..D+1 edges back) all differ from the accepted one.
  logic [D:0]  m_h [2];
  logic        m_st [2];
  logic        m_pend [2];
  logic [15:0] m_swh [2];
  logic [15:0] m_latch;
  logic        m_swr, m_ledr;
  logic [11:0] m_led;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_h[i] = '0; m_st[i] = 1'b0; m_pend[i] = 1'b0; m_swh[i] = '0;
    end
    m_latch = '0; m_swr = 1'b0; m_ledr = 1'b0; m_led = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'b00:   return {30'b0, m_swr, m_ledr};
      2'b01:   return {16'b0, m_latch};
      default: return 32'b0;
    endcase
  endfunction

  task automatic m_edge();
    logic raw [2];
    logic all_diff;
    if (!reset) return;
    raw[0] = btnL;
    raw[1] = btnR;
    if (pWrite && addr == 2'b01) m_led = writeData;
    if (m_pend[1]) begin
      m_swr = 1'b1; m_latch = m_swh[1];
    end else if (pRead && addr == 2'b01) m_swr = 1'b0;
    if (m_pend[0]) m_ledr = 1'b1;
    else if (pWrite && addr == 2'b01) m_ledr = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_pend[b] = 1'b0;
      all_diff = 1'b1;
      for (int k = 1; k <= D; k++) if (m_h[b][k] == m_st[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_st[b]   = ~m_st[b];
        m_pend[b] = m_st[b];
      end
      m_h[b] = {m_h[b][D-1:0], raw[b]};
    end
    m_swh[1] = m_swh[0];
    m_swh[0] = switch;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag);
    #1;
    chk({tag, ".rd"}, readData, m_read(addr));
    chk({tag, ".led"}, {20'b0, led}, {20'b0, m_led});
  endtask

  initial begin
    int hold_l, hold_r;
    m_reset();
    btnL = 1'b1; btnR = 1'b1; switch = 16'hFFFF; reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1 chk("rst_rd", readData, 32'h0);
    end
    chk("rst_led", {20'b0, led}, 32'h0);

    btnL = 1'b0; btnR = 1'b0; addr = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) begin check_outs("idle"); cyc(); end

    // Switch capture: flag visible after the 7th edge, cleared by the data read.
    switch = 16'hA5C3; btnR = 1'b1; addr = 2'b00;
    for (int e = 1; e <= 7; e++) begin
      cyc();
      if (e == 6) chk("swcap.e6", readData, 32'h0);
      if (e == 7) chk("swcap.e7", readData, 32'h2);
    end
    pRead = 1'b1; addr = 2'b01;
    #1 chk("swcap.data", readData, 32'h0000A5C3);
    cyc();
    pRead = 1'b0; addr = 2'b00;
    #1 chk("swcap.clr", readData, 32'h0);
    repeat (4) cyc();
    btnR = 1'b0;
    repeat (8) begin check_outs("swrel"); cyc(); end

    // LED write consumes led_ready.
    btnL = 1'b1;
    repeat (8) cyc();
    #1 chk("ledw.rdy", readData, 32'h1);
    pWrite = 1'b1; addr = 2'b01; writeData = 12'h5A5;
    cyc();
    pWrite = 1'b0; addr = 2'b00;
    #1 chk("ledw.led", {20'b0, led}, 32'h5A5);
    chk("ledw.clr", readData, 32'h0);
    btnL = 1'b0;
    repeat (8) begin check_outs("ledrel"); cyc(); end

    // Randomized run: variable-length button holds (bounces and real presses),
    // random bus traffic and occasional async resets.
    hold_l = 0; hold_r = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold_l == 0) begin btnL = 1'($urandom_range(0, 1)); hold_l = $urandom_range(1, 9); end
      if (hold_r == 0) begin btnR = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 9); end
      hold_l--; hold_r--;
      if ($urandom_range(0, 7) == 0) switch = 16'($urandom);
      addr      = 2'($urandom_range(0, 3));
      pRead     = ($urandom_range(0, 3) == 0);
      pWrite    = ($urandom_range(0, 3) == 0);
      writeData = 12'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        m_reset();
      end else begin
        reset = 1'b1;
      end
      check_outs("rnd");
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
